amba_ahb_arbiter: RTL and testbench

//  Multi-master AHB-lite bus arbiter for the amba DUT: NUM_MASTERS requesters share one address/data bus.

---
 rtl/amba_pkg.sv | 37 +++
 rtl/amba_rr_picker.sv | 35 +++
 rtl/amba_ahb_arbiter.sv | 140 ++++++++++++++
 tb/tb_amba_ahb_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/amba_pkg.sv
// amba_pkg: shared AHB types and helpers for the amba arbiter slice.
//   htrans_e   - AHB transfer type encoding
//   hburst_e   - AHB burst type encoding
//   burst_beats- beats in a burst (undefined-length INCR capped at max_beats)
package amba_pkg;

  localparam int AMBA_MAX_MASTERS = 16;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'd0,
    HT_BUSY   = 2'd1,
    HT_NONSEQ = 2'd2,
    HT_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'd0,
    HB_INCR   = 3'd1,
    HB_WRAP4  = 3'd2,
    HB_INCR4  = 3'd3,
    HB_WRAP8  = 3'd4,
    HB_INCR8  = 3'd5,
    HB_WRAP16 = 3'd6,
    HB_INCR16 = 3'd7
  } hburst_e;

  function automatic logic [7:0] burst_beats(hburst_e b, logic [7:0] max_beats);
    case (b)
      HB_SINGLE:          return 8'd1;
      HB_INCR:            return max_beats;
      HB_WRAP4, HB_INCR4: return 8'd4;
      HB_WRAP8, HB_INCR8: return 8'd8;
      default:            return 8'd16;
    endcase
  endfunction

endpackage

// File: rtl/amba_rr_picker.sv
// amba_rr_picker: combinational round-robin picker.
//   req - request vector
//   ptr - index where the upward scan starts (wraps at N)
//   gnt - one-hot winner (all zero when nothing requests)
//   vld - at least one request present
module amba_rr_picker #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          vld
);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  always_comb begin
    gnt = '0;
    vld = 1'b0;
    sum = '0;
    idx = '0;
    for (int off = 0; off < N; off++) begin
      sum = {1'b0, ptr} + (IW+1)'(off);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      idx = sum[IW-1:0];
      if (!vld && req[idx]) begin
        gnt[idx] = 1'b1;
        vld      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/amba_ahb_arbiter.sv
// amba_ahb_arbiter: round-robin, burst-aware AHB-lite bus arbiter.
// Grant only moves at transfer boundaries (IDLE or last beat of a burst);
// with no requests the bus parks on DEFAULT_MASTER.
// Optional feature macro: AMBA_ARB_LOCK_EN (locked transfers hold the grant).
// Ports:
//   clk, reset_n  - clock, async active-low reset
//   hbusreq/hlock - per-master request / lock request
//   htrans/hburst - transfer and burst type of the current owner
//   hready        - bus ready; low freezes every register here
//   hgrant        - registered one-hot grant
//   hmaster       - registered address-phase owner index
//   hmastlock     - registered locked-transfer flag
module amba_ahb_arbiter
  import amba_pkg::*;
#(
  parameter  int NUM_MASTERS    = 4,
  parameter  int DEFAULT_MASTER = 0,
  parameter  int MAX_BEATS      = 16,
  localparam int IW             = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [IW-1:0]          hmaster,
  output logic                   hmastlock
);

  localparam logic [NUM_MASTERS-1:0] PARK    = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [IW-1:0]          PTR_RST = IW'((DEFAULT_MASTER + 1) % NUM_MASTERS);
  localparam logic [7:0]             MAX_B   = 8'(MAX_BEATS);

  htrans_e trans;
  assign trans = htrans_e'(htrans);

  logic [7:0]             beat_cnt, beat_cnt_nxt, burst_len, burst_len_nxt;
  logic [IW-1:0]          rr_ptr, ptr_nxt, owner, pick_idx;
  logic [NUM_MASTERS-1:0] elig, pick, grant_nxt;
  logic                   pick_vld, arb, hold_grant;

  // Beat accounting; the next-state values feed the ARB test so a final
  // beat and a fresh NONSEQ are judged against the newly loaded length.
  always_comb begin
    beat_cnt_nxt  = beat_cnt;
    burst_len_nxt = burst_len;
    if (hready) begin
      case (trans)
        HT_NONSEQ: begin
          burst_len_nxt = burst_beats(hburst_e'(hburst), MAX_B);
          beat_cnt_nxt  = 8'd1;
        end
        HT_SEQ:  if (beat_cnt < burst_len) beat_cnt_nxt = beat_cnt + 8'd1;
        HT_IDLE: beat_cnt_nxt = 8'd0;
        default: ;
      endcase
    end
  end

  assign arb = hready & ((trans == HT_IDLE) | (htrans[1] & (beat_cnt_nxt == burst_len_nxt)));

  always_comb begin
    owner    = '0;
    pick_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (hgrant[i]) owner    = IW'(i);
      if (pick[i])   pick_idx = IW'(i);
    end
  end

  // Owner is excluded only when someone else wants the bus, so a lone
  // requester keeps the grant while contention forces it to move on.
  always_comb begin
    elig = hbusreq & ~hgrant;
    if (elig == '0) elig = hbusreq;
  end

  amba_rr_picker #(.N(NUM_MASTERS)) u_pick (
    .req (elig),
    .ptr (rr_ptr),
    .gnt (pick),
    .vld (pick_vld)
  );

`ifdef AMBA_ARB_LOCK_EN
  // lock_hold keeps the grant for one further transfer after hlock drops.
  logic lock_hold;
  assign hold_grant = hlock[owner] | lock_hold;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_hold <= 1'b0;
      hmastlock <= 1'b0;
    end else if (hready) begin
      if (arb) lock_hold <= hlock[owner];
      hmastlock <= hlock[owner];
    end
  end
`else
  logic unused_hlock;
  assign unused_hlock = ^hlock;
  assign hold_grant   = 1'b0;
  assign hmastlock    = 1'b0;
`endif

  always_comb begin
    grant_nxt = hgrant;
    ptr_nxt   = rr_ptr;
    if (arb && !hold_grant) begin
      if (!pick_vld) begin
        grant_nxt = PARK;
      end else begin
        grant_nxt = pick;
        if (pick != hgrant)
          ptr_nxt = (pick_idx == IW'(NUM_MASTERS - 1)) ? '0 : pick_idx + 1'b1;
      end
    end
  end

  // hmaster follows the grant one ready edge later (address-phase handover).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hgrant    <= PARK;
      hmaster   <= IW'(DEFAULT_MASTER);
      rr_ptr    <= PTR_RST;
      beat_cnt  <= 8'd0;
      burst_len <= 8'd0;
    end else if (hready) begin
      hgrant    <= grant_nxt;
      hmaster   <= owner;
      rr_ptr    <= ptr_nxt;
      beat_cnt  <= beat_cnt_nxt;
      burst_len <= burst_len_nxt;
    end
  end

endmodule

// File: tb/tb_amba_ahb_arbiter.sv
// tb_amba_ahb_arbiter: directed bench for amba_ahb_arbiter (N=4, DEFAULT=0,
// MAX_BEATS=16). Inputs change 1ns after a rising edge; outputs are sampled there.
module tb_amba_ahb_arbiter;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] hbusreq, hlock;
  logic [1:0]   htrans;
  logic [2:0]   hburst;
  logic         hready;
  logic [N-1:0] hgrant;
  logic [1:0]   hmaster;
  logic         hmastlock;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  amba_ahb_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(0), .MAX_BEATS(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .hbusreq   (hbusreq),
    .hlock     (hlock),
    .htrans    (htrans),
    .hburst    (hburst),
    .hready    (hready),
    .hgrant    (hgrant),
    .hmaster   (hmaster),
    .hmastlock (hmastlock)
  );

  localparam logic [1:0] IDLE = 2'd0, NSEQ = 2'd2, SEQ = 2'd3;
  localparam logic [2:0] SINGLE = 3'd0, INCR = 3'd1, INCR4 = 3'd3, INCR8 = 3'd5;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; hbusreq = '0; hlock = '0;
    htrans = IDLE; hburst = SINGLE; hready = 1'b1;
    repeat (3) step();
    chk("rst_grant", 32'(hgrant), 32'h1);
    chk("rst_master", 32'(hmaster), 32'h0);
    chk("rst_lock", 32'(hmastlock), 32'h0);
    reset_n = 1'b1;

    // 1: parked on M0
    for (int i = 0; i < 20; i++) begin
      step();
      chk("park_grant", 32'(hgrant), 32'h1);
      chk("park_master", 32'(hmaster), 32'h0);
    end
    chk("park_lock", 32'(hmastlock), 32'h0);

    // 2: M1,M2 request; SINGLEs alternate the grant
    hbusreq = 4'b0110;
    step();
    chk("rr_first", 32'(hgrant), 32'h2);
    chk("rr_first_master", 32'(hmaster), 32'h0);
    htrans = NSEQ; hburst = SINGLE;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_alt_grant", 32'(hgrant), (i % 2 == 0) ? 32'h4 : 32'h2);
      chk("rr_alt_master", 32'(hmaster), (i % 2 == 0) ? 32'h1 : 32'h2);
    end

    // 3: M3 INCR4 with M0 waiting
    htrans = IDLE; hbusreq = 4'b1000;
    step();
    chk("m3_grant", 32'(hgrant), 32'h8);
    hbusreq = 4'b1001; htrans = NSEQ; hburst = INCR4;
    step();
    chk("incr4_b1", 32'(hgrant), 32'h8);
    htrans = SEQ;
    step(); chk("incr4_b2", 32'(hgrant), 32'h8);
    step(); chk("incr4_b3", 32'(hgrant), 32'h8);
    step(); chk("incr4_end", 32'(hgrant), 32'h1);

    // 4: M2 INCR capped at 16 beats, M1 waiting
    htrans = IDLE; hbusreq = 4'b0100;
    step();
    chk("m2_grant", 32'(hgrant), 32'h4);
    hbusreq = 4'b0110; htrans = NSEQ; hburst = INCR;
    step();
    chk("incr_b1", 32'(hgrant), 32'h4);
    htrans = SEQ;
    for (int b = 2; b <= 15; b++) begin
      step();
      chk("incr_hold", 32'(hgrant), 32'h4);
    end
    step();
    chk("incr_cap", 32'(hgrant), 32'h2);

    // 5: handover stalled by hready low
    htrans = IDLE; hbusreq = 4'b0001;
    step();
    chk("stall_grant", 32'(hgrant), 32'h1);
    chk("stall_m_old", 32'(hmaster), 32'h1);
    hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_master", 32'(hmaster), 32'h1);
      chk("stall_grant_hold", 32'(hgrant), 32'h1);
    end
    hready = 1'b1;
    step();
    chk("stall_release", 32'(hmaster), 32'h0);

    // 5b: async reset in the middle of an M1 INCR8
    hbusreq = 4'b0010;
    step();
    chk("m1_grant", 32'(hgrant), 32'h2);
    htrans = NSEQ; hburst = INCR8;
    step();
    htrans = SEQ;
    repeat (3) step();
    chk("pre_rst_grant", 32'(hgrant), 32'h2);
    chk("pre_rst_master", 32'(hmaster), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_grant", 32'(hgrant), 32'h1);
    chk("async_rst_master", 32'(hmaster), 32'h0);
    htrans = IDLE; hburst = SINGLE; hbusreq = '0;
    step();
    reset_n = 1'b1;

    // 6: locked M1 with M0,M2 requesting
    hbusreq = 4'b0111; hlock = 4'b0010;
    step();
    chk("lk_grant", 32'(hgrant), 32'h2);
    htrans = NSEQ; hburst = SINGLE;
`ifdef AMBA_ARB_LOCK_EN
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lk_hold", 32'(hgrant), 32'h2);
      chk("lk_mastlock", 32'(hmastlock), 32'h1);
    end
    hlock = '0;
    step();
    chk("lk_extra", 32'(hgrant), 32'h2);
    chk("lk_mastlock_off", 32'(hmastlock), 32'h0);
    step();
    chk("lk_release", 32'(hgrant), 32'h4);
`else
    step();
    chk("nolk_grant", 32'(hgrant), 32'h4);
    chk("nolk_mastlock", 32'(hmastlock), 32'h0);
    step();
    chk("nolk_next", 32'(hgrant), 32'h1);
    chk("nolk_mastlock2", 32'(hmastlock), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
